obi_burst_reader: RTL and testbench

- OBI manager (initiator) that reads a contiguous block of 32-bit words from the system bus. It is the requesting end of the same OBI subordinate protocol that the user-domain peripherals answer.
- Software-facing control (start/base/count) arrives from a local register block in the user domain. Fetched words are buffered and presented on a valid/ready stream for a downstream consumer, e.g. a hash core.
- The block keeps several reads in flight and never stalls the OBI response channel.

---
 rtl/obi_burst_reader_pkg.sv | 25 ++
 rtl/obi_burst_reader_fifo.sv | 50 +++++
 rtl/obi_burst_reader.sv | 123 ++++++++++++
 tb/tb_obi_burst_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_burst_reader_pkg.sv
// obi_burst_reader_pkg: shared types and constants for the OBI burst reader.
// Contents: the FSM state enum, a word-stride helper and the register-block
// offsets for the control registers that drive start/base/count.
package obi_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    // Byte distance between consecutive words for a given bus data width.
    function automatic int unsigned word_stride(input int unsigned data_width);
        return data_width / 8;
    endfunction

    localparam int unsigned DEFAULT_WORD_STRIDE = 4;

    localparam logic [7:0] REG_CTRL_OFFSET   = 8'h00;
    localparam logic [7:0] REG_BASE_OFFSET   = 8'h04;
    localparam logic [7:0] REG_COUNT_OFFSET  = 8'h08;
    localparam logic [7:0] REG_STATUS_OFFSET = 8'h0C;

endpackage

// File: rtl/obi_burst_reader_fifo.sv
// obi_burst_reader_fifo: synchronous FIFO buffering fetched words for the output stream.
// Ports: clk_i/rst_i (sync active-high), push_i/data_i write side,
// pop_i read side (ignored when empty), data_o head word (0 when empty),
// full_o/empty_o status, count_o current fill level.
module obi_burst_reader_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(Depth);
    assign count_o = cnt_q;
    // Gate the head so the stream data reads 0 out of reset and when empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q == PW'(Depth - 1) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q == PW'(Depth - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/obi_burst_reader.sv
// obi_burst_reader: OBI read manager fetching a contiguous word block into a valid/ready stream.
// Ports: clk_i/rst_i (sync active-high); start_i/base_addr_i/num_words_i launch a
// transfer; busy_o/done_o/err_o report status; obi_* is the OBI manager port
// (read only); data_valid_o/data_o/data_ready_i is the output stream.
module obi_burst_reader
    import obi_burst_reader_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned LenWidth       = 16,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned FifoDepth      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [LenWidth-1:0]    num_words_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   obi_req_o,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    input  logic                   obi_gnt_i,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i,
    output logic                   data_valid_o,
    output logic [DataWidth-1:0]   data_o,
    input  logic                   data_ready_i
);

    localparam int unsigned Stride = word_stride(DataWidth);
    localparam int unsigned OW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned CW     = $clog2(FifoDepth + 1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_full, fifo_empty;
    logic                 start_ok, hs, push, pop, credit;

    assign start_ok = start_i && state_q == IDLE;
    assign hs       = obi_req_o && obi_gnt_i;
    // Responses outside a transfer (e.g. after a reset) are dropped.
    assign push     = obi_rvalid_i && busy_o && outst_q != '0;
    assign pop      = data_valid_o && data_ready_i;
    // Every in-flight read must already own a FIFO slot so no response is lost.
    assign credit   = 32'(outst_q) < MaxOutstanding
                   && 32'(outst_q) + 32'(fifo_cnt) < FifoDepth
                   && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? (num_words_i != '0 ? ISSUE : DONE) : IDLE;
            ISSUE:   state_d = hs && remaining_q == LenWidth'(1) ? WAIT : ISSUE;
            WAIT:    state_d = outst_q == '0 ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = state_q == ISSUE || state_q == WAIT;
        done_o    = state_q == DONE;
        obi_req_o = state_q == ISSUE && credit;
    end

    always_comb begin
        addr_d      = start_ok ? (base_addr_i & ~AddrWidth'(3))
                    : hs       ? addr_q + AddrWidth'(Stride) : addr_q;
        remaining_d = start_ok ? num_words_i : hs ? remaining_q - 1'b1 : remaining_q;
        err_d       = (push && obi_err_i) || (err_q && !start_ok);
        outst_d     = outst_q + OW'(hs) - OW'(push);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
        end
    end

    obi_burst_reader_fifo #(
        .Depth (FifoDepth),
        .Width (DataWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (obi_rdata_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign data_valid_o = !fifo_empty;
    assign obi_addr_o   = addr_q;
    assign obi_we_o     = 1'b0;
    assign obi_be_o     = '1;
    assign err_o        = err_q;

endmodule

// File: tb/tb_obi_burst_reader.sv
// tb_obi_burst_reader: scoreboard bench for the OBI burst reader with a simple OBI subordinate model.
module tb_obi_burst_reader;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [31:0] base_addr_i;
    logic [15:0] num_words_i;
    logic        busy_o, done_o, err_o;
    logic        obi_req_o, obi_we_o, obi_gnt_i, obi_rvalid_i, obi_err_i;
    logic [31:0] obi_addr_o, obi_rdata_i, data_o;
    logic [3:0]  obi_be_o;
    logic        data_valid_o, data_ready_i;

    always #5 clk = ~clk;

    obi_burst_reader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .obi_req_o    (obi_req_o),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .data_ready_i (data_ready_i)
    );

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] data_base = '0;
    logic [31:0] stall_exp = '0;
    int          resp_idx = 0;
    int          err_idx = -1;
    int          hs_total = 0;
    int          pending = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    int          stall_cycles = 0;
    logic        hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] base, input logic [15:0] n, input logic [31:0] dbase,
                       input int na, input int nd);
        for (int k = 0; k < na; k++) exp_addr.push_back((base & ~32'h3) + 32'(4 * k));
        for (int k = 0; k < nd; k++) exp_data.push_back(dbase + 32'(k));
        data_base   = dbase;
        resp_idx    = 0;
        hs_total    = 0;
        base_addr_i = base;
        num_words_i = n;
        start_i     = 1'b1;
        tick;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(done_o), 32'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    // OBI subordinate: in-order responses one cycle after grant, optional
    // response hold and a programmable grant stall on one request.
    initial begin
        logic hs;
        obi_gnt_i    = 1'b1;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        obi_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            hs = obi_req_o && obi_gnt_i;
            if (hs) hs_total++;
            if (obi_req_o && !obi_gnt_i && stall_left > 0) stall_left--;
            @(posedge clk);
            #2;
            if (hs) pending++;
            obi_rvalid_i = pending > 0 && !hold;
            obi_rdata_i  = data_base + 32'(resp_idx);
            obi_err_i    = obi_rvalid_i && resp_idx == err_idx;
            if (obi_rvalid_i) begin
                pending--;
                resp_idx++;
            end
            obi_gnt_i = !(stall_left > 0 && hs_total == stall_idx);
        end
    end

    // Monitor: compares stream words, request addresses and stalled addresses.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (data_valid_o && data_ready_i) begin
                if (exp_data.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL stream_extra: got %h, expected no word", data_o);
                end else begin
                    e = exp_data.pop_front();
                    chk("stream", data_o, e);
                end
            end
            if (obi_req_o && obi_gnt_i) begin
                if (exp_addr.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL addr_extra: got %h, expected no request", obi_addr_o);
                end else begin
                    e = exp_addr.pop_front();
                    chk("addr", obi_addr_o, e);
                end
            end
            if (obi_req_o && !obi_gnt_i) begin
                stall_cycles++;
                chk("stall_addr", obi_addr_o, stall_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        num_words_i  = '0;
        data_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_req", 32'(obi_req_o), 0);
        chk("rst_addr", obi_addr_o, 0);
        chk("rst_we", 32'(obi_we_o), 0);
        chk("rst_be", 32'(obi_be_o), 32'hF);
        chk("rst_valid", 32'(data_valid_o), 0);
        chk("rst_data", data_o, 0);
        tick;
        rst_i = 1'b0;

        // Basic read
        run(32'h1000_0000, 4, 32'hA0, 4, 4);
        wait_done("basic");
        chk("basic_err", 32'(err_o), 0);
        repeat (5) tick;

        // Backpressure
        data_ready_i = 1'b0;
        run(32'h3000_0000, 8, 32'hB0, 8, 8);
        repeat (20) tick;
        chk("bp_grants", 32'(hs_total), 4);
        chk("bp_req", 32'(obi_req_o), 0);
        chk("bp_busy", 32'(busy_o), 1);
        chk("bp_valid", 32'(data_valid_o), 1);
        data_ready_i = 1'b1;
        wait_done("bp");
        repeat (10) tick;

        // Grant stall on the 2nd request
        stall_exp    = 32'h2000_0004;
        stall_cycles = 0;
        stall_idx    = 1;
        stall_left   = 5;
        run(32'h2000_0000, 4, 32'hC0, 4, 4);
        wait_done("stall");
        chk("stall_cycles", 32'(stall_cycles), 5);
        stall_idx = -1;
        repeat (5) tick;

        // Error on word 2, then zero-length transfer
        err_idx = 1;
        run(32'h4000_0000, 3, 32'hD0, 3, 3);
        wait_done("err");
        chk("err_set", 32'(err_o), 1);
        repeat (3) tick;
        chk("err_sticky", 32'(err_o), 1);
        err_idx = -1;
        run(32'h4444_0000, 0, 32'h0, 0, 0);
        @(negedge clk);
        chk("zero_done", 32'(done_o), 1);
        chk("zero_err_clr", 32'(err_o), 0);
        chk("zero_req", 32'(obi_req_o), 0);
        chk("zero_busy", 32'(busy_o), 0);
        @(negedge clk);
        chk("zero_done_pulse", 32'(done_o), 0);
        repeat (3) tick;

        // Address wrap with an ignored start mid-transfer
        run(32'hFFFF_FFF8, 3, 32'hE0, 3, 3);
        tick;
        base_addr_i = 32'h5555_0000;
        num_words_i = 5;
        start_i     = 1'b1;
        tick;
        start_i     = 1'b0;
        wait_done("wrap");
        repeat (5) tick;
        chk("wrap_grants", 32'(hs_total), 3);
        chk("wrap_busy", 32'(busy_o), 0);

        // Reset with two reads outstanding
        hold = 1'b1;
        run(32'h7000_0000, 4, 32'hF0, 2, 0);
        repeat (5) tick;
        chk("rr_grants", 32'(hs_total), 2);
        chk("rr_req", 32'(obi_req_o), 0);
        chk("rr_busy", 32'(busy_o), 1);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rr_busy0", 32'(busy_o), 0);
        chk("rr_req0", 32'(obi_req_o), 0);
        chk("rr_addr0", obi_addr_o, 0);
        chk("rr_valid0", 32'(data_valid_o), 0);
        chk("rr_err0", 32'(err_o), 0);
        tick;
        hold = 1'b0;
        repeat (6) tick;
        chk("rr_late_valid", 32'(data_valid_o), 0);
        chk("rr_late_busy", 32'(busy_o), 0);
        run(32'h6000_0003, 2, 32'h11, 2, 2);
        wait_done("post_rst");
        repeat (8) tick;

        chk("left_data", 32'(exp_data.size()), 0);
        chk("left_addr", 32'(exp_addr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
